// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the memory access sequencer: FSM states, op codes, default widths.
package cpu_mem_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } mem_op_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// Control-unit <-> memory sequencer bus: MAR/MDR request side and MDR load side.
// err is only present when ADDR_GUARD_EN is defined.
interface mem_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) ();

    logic [ADDR_W-1:0] mar_addr;
    logic [DATA_W-1:0] mdr_data;
    logic              rd_req;
    logic              wr_req;
    logic [DATA_W-1:0] from_ram;
    logic              read_ram;
    logic              done;
    logic              busy;
`ifdef ADDR_GUARD_EN
    logic              err;
`endif

    modport master (
        output mar_addr, mdr_data, rd_req, wr_req,
`ifdef ADDR_GUARD_EN
        input  err,
`endif
        input  from_ram, read_ram, done, busy
    );

    modport slave (
        input  mar_addr, mdr_data, rd_req, wr_req,
`ifdef ADDR_GUARD_EN
        output err,
`endif
        output from_ram, read_ram, done, busy
    );

endinterface

// File: rtl/mem_ctrl_ram_array.sv
// Single-port synchronous RAM, DEPTH x DATA_W, read-first with registered rdata (1 cycle).
// No flow control; contents are never reset.
module ram_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_ctrl.sv
// Fixed-latency RAM access sequencer: request at edge 0 -> done in cycle WAIT_CYCLES+2.
// Requests while busy are dropped (no buffering); ADDR_GUARD_EN adds range check and err.
module mem_ctrl
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       clr,
    mem_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    mem_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    mem_op_t           op_q;
    logic [DATA_W-1:0] from_ram_q;
    logic              read_ram_q;
    logic              done_q;
    logic              busy_q;
    logic              in_range;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

`ifdef ADDR_GUARD_EN
    logic              err_q;
    assign in_range = (32'(addr_q) < 32'(DEPTH));
    assign bus.err  = err_q;
`else
    assign in_range = 1'b1;
`endif

    // The array is addressed one cycle ahead so its registered rdata is ready during XFER,
    // including the WAIT_CYCLES=0 case where XFER directly follows the IDLE sample edge.
    assign ram_addr = (state == IDLE) ? bus.mar_addr : addr_q;
    assign ram_we   = (state == XFER) && (op_q == OP_WR) && in_range;

    ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_q       <= OP_RD;
            from_ram_q <= '0;
            read_ram_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef ADDR_GUARD_EN
            err_q      <= 1'b0;
`endif
        end else begin
            read_ram_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef ADDR_GUARD_EN
            err_q      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.rd_req || bus.wr_req) begin
                        addr_q  <= bus.mar_addr;
                        wdata_q <= bus.mdr_data;
                        op_q    <= bus.wr_req ? OP_WR : OP_RD;
                        cnt     <= WAIT_INIT;
                        busy_q  <= 1'b1;
                        state   <= (WAIT_CYCLES == 0) ? XFER : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= XFER;
                    end
                end
                XFER: begin
                    state  <= DONE;
                    done_q <= 1'b1;
                    if (op_q == OP_RD) begin
                        read_ram_q <= 1'b1;
                        from_ram_q <= in_range ? ram_rdata : '0;
                    end
`ifdef ADDR_GUARD_EN
                    err_q <= !in_range;
`endif
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.from_ram = from_ram_q;
    assign bus.read_ram = read_ram_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;

endmodule
